reflex_ctrl: RTL and testbench
==============================

# reflex_ctrl

Game sequencer for the reaction-time tester. A round starts on `start`, waits a pseudo-random delay, lights the GO LED, and counts milliseconds until `btn`. It then drives the eight 4-bit digit inputs of the eight-digit multiplexed display: current result on the low four digits, best result on the high four. Early presses are flagged as fouls.

## Interface
Parameters:
- `TICK_DIV`, 100_000: clock cycles per millisecond tick (100 MHz clock).
- `MIN_WAIT_MS`, 1000: minimum random delay, in ms.

Ports:
- `ck`  in  1  system clock; one clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse, already debounced and synchronised; starts a round.
- `btn`  in  1  one-cycle pulse, already debounced and synchronised; player reaction.
- `led_go`  out  1  GO indicator.
- `busy`  out  1  high while a round is in progress (WAIT or GO).
- `seg0`..`seg3`  out  4 each  current result, BCD; `seg0` = ms units, `seg3` = thousands.
- `seg4`..`seg7`  out  4 each  best result, BCD; `seg4` = units, `seg7` = thousands.

## Operation
- States: IDLE, WAIT, GO, DONE, FOUL. `led_go = (state==GO)`. `busy = (state==WAIT || state==GO)`. Both are decoded from the state register.
- Tick divider:
  - Counts 0..TICK_DIV-1.
  - `tick` is a one-cycle pulse when the count equals TICK_DIV-1.
  - Divider clears to 0 on every state transition, so the first tick comes TICK_DIV cycles after entry.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Advances every cycle in every state.
  - Never reaches 0.
- IDLE:
  - `start` -> WAIT.
  - Loads `wait_ms` = MIN_WAIT_MS + lfsr[11:0] (14-bit, max MIN_WAIT_MS+4095).
  - Clears current result to 0000. `btn` is ignored.
- WAIT:
  - Each tick decrements `wait_ms`.
  - A tick while `wait_ms`==1 -> GO, with result already 0000.
  - `btn` -> FOUL. `btn` has priority over expiry in the same cycle.
  - `start` is ignored.
- GO:
  - Each tick increments the 4-digit BCD result, with per-digit carry 9->0.
  - Saturates at 9999 and holds there.
  - `btn` -> DONE. If `btn` and tick arrive in the same cycle, `btn` wins and there is no increment.
  - `start` is ignored.
- DONE:
  - Result is frozen.
  - On the entry edge, if result < best (unsigned BCD compare, most-significant digit first), best <= result.
  - `start` -> WAIT with a new `wait_ms` load and result cleared. `btn` is ignored.
- FOUL:
  - `seg3..seg0` show 4'hF each. Best is unchanged.
  - `start` -> WAIT as in DONE. `btn` is ignored.
- Best register:
  - Reset value is 9999.
  - Persists across rounds; only `rst_n` restores it.
- Reset, including mid-round:
  - State IDLE, divider 0, LFSR seed, `wait_ms` 0.
  - Result 0000, best 9999, `led_go`=0, `busy`=0.
  - `seg0..3`=4'h0, `seg4..7`=4'h9.

## Timing
- `start` sampled at edge N: state is WAIT after edge N, and `busy`=1 from cycle N+1.
- WAIT duration: exactly `wait_ms`·TICK_DIV cycles. `led_go` rises on the cycle after the final tick.
- Result = number of complete ticks between GO entry and the `btn` edge (truncation, no rounding).
- `btn` sampled at edge M in GO: `led_go`=0 and `busy`=0 from cycle M+1. Best is updated at edge M+1 and visible on `seg4..7` from cycle M+2.
- All `seg*` outputs are registered (or decoded from registers) with no combinational path from inputs.

## Test plan
Bench parameters: TICK_DIV=4, MIN_WAIT_MS=2.
1. Reset, then idle for 20 cycles.
   - `seg7..0` = 9,9,9,9,0,0,0,0.
   - `led_go`=0, `busy`=0.
   - `btn` pulses cause no change.
2. `start`, then `btn` 13 cycles after `led_go` rises.
   - `seg3..0` = 0003.
   - Best updates to 0003 two cycles after `btn`.
   - WAIT length equals (2+lfsr[11:0] at start)·4 cycles, checked against a reference LFSR model.
3. Second round with `btn` after 7 cycles (result 0001), then third round with `btn` after 40 cycles (result 0010).
   - Best is 0001 after round 2.
   - Best stays 0001 after round 3.
4. `btn` during WAIT.
   - FOUL state: `seg3..0` = F,F,F,F.
   - `led_go` never asserts, best unchanged.
   - `start` re-enters WAIT.
5. Hold off `btn` in GO for 10000·4+8 cycles.
   - Result saturates and holds at 9999.
   - `btn` -> DONE. Best unchanged if best < 9999.
   - Boundary: `btn` coincident with a tick leaves the count un-incremented.
6. Assert `rst_n`=0 asynchronously mid-GO (between clock edges).
   - All outputs go immediately to their reset values.
   - After release, state is IDLE, and the next `start` runs a normal round.

Source files
------------

// File: rtl/reflex_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reflex_ctrl_if
// Description : Player controls and display/indicator bundle of the
//               reaction-time tester. The master drives the start/btn pulses;
//               the slave (the sequencer) drives the GO LED, busy flag and
//               the eight BCD digit nibbles of the multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
interface reflex_ctrl_if;
  logic       start;
  logic       btn;
  logic       led_go;
  logic       busy;
  logic [3:0] seg0;
  logic [3:0] seg1;
  logic [3:0] seg2;
  logic [3:0] seg3;
  logic [3:0] seg4;
  logic [3:0] seg5;
  logic [3:0] seg6;
  logic [3:0] seg7;

  modport master (
    output start, btn,
    input  led_go, busy,
    input  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport slave (
    input  start, btn,
    output led_go, busy,
    output seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );
endinterface : reflex_ctrl_if
`default_nettype wire

// File: rtl/reflex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reflex_ctrl
// Description : Reaction-time game sequencer. A round waits a pseudo-random
//               number of milliseconds, lights GO, then counts milliseconds
//               in BCD until the player presses. Current result drives the
//               low four display digits, best-ever result the high four.
//               Presses before GO are reported as fouls (FFFF).
// Revision    : 1.0 - initial release
// ============================================================================
module reflex_ctrl #(
  parameter int TICK_DIV    = 100_000,
  parameter int MIN_WAIT_MS = 1000
) (
  input  logic         ck,
  input  logic         rst_n,
  reflex_ctrl_if.slave bus
);

  // Divider width; a divide-by-one still needs a one-bit counter.
  localparam int                 c_DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
  localparam logic [13:0]        c_MIN_WAIT  = 14'(MIN_WAIT_MS);
  localparam logic [15:0]        c_LFSR_SEED = 16'hACE1;
  localparam logic [15:0]        c_BCD_MAX   = 16'h9999;
  localparam logic [15:0]        c_BCD_ZERO  = 16'h0000;
  localparam logic [15:0]        c_FOUL_SHOW = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_DIV_W-1:0] r_div;
  logic [15:0]        r_lfsr;
  logic [13:0]        r_wait_ms;
  logic [15:0]        r_result;     // four packed BCD digits, [3:0] = units
  logic [15:0]        r_best;       // four packed BCD digits, [3:0] = units
  logic               w_tick;
  logic               w_change;
  logic               w_load;
  logic               w_lfsr_fb;
  logic [15:0]        w_seg_cur;

  // Increment four packed BCD digits with ripple carry 9 -> 0. The caller
  // guards 9999 so the top carry is never lost.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] o;
    logic        c;
    o = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          o[i*4 +: 4] = 4'd0;
        end else begin
          o[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return o;
  endfunction

  // Millisecond strobe on the last count of the divider.
  assign w_tick = (r_div == c_DIV_MAX);

  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Next-state decode; btn is checked before the wait expiry so an early
  // press on the expiry cycle is still a foul.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.btn) begin
          w_state_nxt = S_FOUL;
        end else if (w_tick && (r_wait_ms == 14'd1)) begin
          w_state_nxt = S_GO;
        end
      end
      S_GO: begin
        if (bus.btn) w_state_nxt = S_DONE;
      end
      S_DONE, S_FOUL: begin
        if (bus.start) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Any state change restarts the divider; entering WAIT from outside
  // loads a fresh random delay and clears the result.
  assign w_change = (w_state_nxt != r_state);
  assign w_load   = (w_state_nxt == S_WAIT) && (r_state != S_WAIT);

  // State register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Millisecond divider, realigned to zero on every transition so the first
  // tick of a state lands a full period after entry.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_change || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_ONE;
    end
  end

  // Free-running LFSR; advances every cycle so the delay depends on when
  // the player presses start.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= c_LFSR_SEED;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // Remaining delay in ms; a press in WAIT leaves it untouched.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_ms <= 14'd0;
    end else if (w_load) begin
      r_wait_ms <= c_MIN_WAIT + {2'b00, r_lfsr[11:0]};
    end else if ((r_state == S_WAIT) && w_tick && !bus.btn) begin
      r_wait_ms <= r_wait_ms - 14'd1;
    end
  end

  // Reaction counter: counts ticks in GO, saturates at 9999, and a press on
  // a tick cycle suppresses that tick.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= c_BCD_ZERO;
    end else if (w_load) begin
      r_result <= c_BCD_ZERO;
    end else if ((r_state == S_GO) && w_tick && !bus.btn && (r_result != c_BCD_MAX)) begin
      r_result <= bcd_inc(r_result);
    end
  end

  // Best-result tracker. Packed BCD orders the same as its value, so a plain
  // unsigned compare is a most-significant-digit-first compare. The result
  // is frozen in DONE, so checking on every DONE cycle is equivalent to
  // checking on the entry cycle only.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_best <= c_BCD_MAX;
    end else if ((r_state == S_DONE) && (r_result < r_best)) begin
      r_best <= r_result;
    end
  end

  // Outputs are decoded purely from registers.
  assign w_seg_cur  = (r_state == S_FOUL) ? c_FOUL_SHOW : r_result;
  assign bus.led_go = (r_state == S_GO);
  assign bus.busy   = (r_state == S_WAIT) || (r_state == S_GO);
  assign bus.seg0   = w_seg_cur[3:0];
  assign bus.seg1   = w_seg_cur[7:4];
  assign bus.seg2   = w_seg_cur[11:8];
  assign bus.seg3   = w_seg_cur[15:12];
  assign bus.seg4   = r_best[3:0];
  assign bus.seg5   = r_best[7:4];
  assign bus.seg6   = r_best[11:8];
  assign bus.seg7   = r_best[15:12];

endmodule : reflex_ctrl
`default_nettype wire

// File: tb/tb_reflex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reflex_ctrl
// Description : Self-checking bench for reflex_ctrl with a fast tick
//               (TICK_DIV=4, MIN_WAIT_MS=2). A behavioural model predicts
//               the wait length, reaction counts and best-result history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reflex_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int MIN_WAIT_MS = 2;

  logic ck    = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_best = 9999;          // model of the best result, plain integer
  logic [15:0] m_lfsr;          // model of the pseudo-random sequence
  logic [15:0] cur;
  logic [15:0] best;

  reflex_ctrl_if bus ();

  reflex_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .MIN_WAIT_MS (MIN_WAIT_MS)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  assign cur  = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  assign best = {bus.seg7, bus.seg6, bus.seg5, bus.seg4};

  // Textbook 16-bit Fibonacci step for taps 16,14,13,11 (shift right).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (b << 15);
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  function automatic int sat(input int n);
    return (n > 9999) ? 9999 : n;
  endfunction

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge ck);
    if (n > 0) #1;
  endtask

  // Wait (bounded) until the model's low 12 bits are small, so delays stay
  // short, then pulse start for one cycle.
  task automatic pick_start(output int exp_wait);
    int guard;
    guard = 0;
    while (m_lfsr[11:0] >= 12'd200 && guard < 5000) begin
      @(posedge ck); #1;
      guard++;
    end
    exp_wait = MIN_WAIT_MS + int'(m_lfsr[11:0]);
    bus.start = 1'b1;
    @(posedge ck); #1;
    bus.start = 1'b0;
  endtask

  // One full round: start, measured wait, press d cycles after GO is seen.
  task automatic run_round(input string nm, input int d);
    int          exp_wait, cnt, exp_res;
    logic [15:0] old_best;
    pick_start(exp_wait);
    checks++;
    if (bus.busy !== 1'b1 || bus.led_go !== 1'b0) begin
      errors++;
      $display("FAIL %s wait_entry: busy=%b led_go=%b, want busy=1 led_go=0", nm, bus.busy, bus.led_go);
    end
    checks++;
    if (cur !== 16'h0000) begin
      errors++;
      $display("FAIL %s wait_result: got %h want 0000", nm, cur);
    end
    cnt = 0;
    while (bus.led_go !== 1'b1 && cnt < exp_wait * TICK_DIV + 16) begin
      @(posedge ck); #1;
      cnt++;
    end
    checks++;
    if (cnt != exp_wait * TICK_DIV) begin
      errors++;
      $display("FAIL %s wait_len: got %0d cycles want %0d", nm, cnt, exp_wait * TICK_DIV);
    end
    if (bus.led_go !== 1'b1) return;
    wait_edges(d / 2);
    checks++;
    if (cur !== to_bcd(sat((d / 2) / TICK_DIV))) begin
      errors++;
      $display("FAIL %s go_mid: got %h want %h", nm, cur, to_bcd(sat((d / 2) / TICK_DIV)));
    end
    wait_edges(d - d / 2);
    exp_res = sat(d / TICK_DIV);
    checks++;
    if (cur !== to_bcd(exp_res) || bus.led_go !== 1'b1) begin
      errors++;
      $display("FAIL %s go_end: got %h led_go=%b want %h led_go=1", nm, cur, bus.led_go, to_bcd(exp_res));
    end
    bus.btn = 1'b1;
    @(posedge ck); #1;
    bus.btn = 1'b0;
    old_best = to_bcd(m_best);
    checks++;
    if (bus.led_go !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: led_go=%b busy=%b want 0 0", nm, bus.led_go, bus.busy);
    end
    checks++;
    if (cur !== to_bcd(exp_res)) begin
      errors++;
      $display("FAIL %s result: got %h want %h", nm, cur, to_bcd(exp_res));
    end
    checks++;
    if (best !== old_best) begin
      errors++;
      $display("FAIL %s best_early: got %h want %h", nm, best, old_best);
    end
    if (exp_res < m_best) m_best = exp_res;
    @(posedge ck); #1;
    checks++;
    if (best !== to_bcd(m_best) || cur !== to_bcd(exp_res)) begin
      errors++;
      $display("FAIL %s best: got %h cur %h want %h cur %h", nm, best, cur, to_bcd(m_best), to_bcd(exp_res));
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.start = 1'b0;
    bus.btn   = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if (cur !== 16'h0000 || best !== 16'h9999 || bus.led_go !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: seg=%h%h led_go=%b busy=%b want 99990000 0 0", best, cur, bus.led_go, bus.busy);
    end
    @(posedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    @(posedge ck); #1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.btn = ($urandom_range(0, 1) == 1);
      @(posedge ck); #1;
      if (cur !== 16'h0000 || best !== 16'h9999 || bus.led_go !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    bus.btn = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_btn: %0d disturbed cycles, want 0", bad);
    end
  endtask

  task automatic test_rounds();
    run_round("round1", 13);
    checks++;
    if (best !== 16'h0003) begin
      errors++;
      $display("FAIL round1_best: got %h want 0003", best);
    end
    run_round("round2", 7);
    checks++;
    if (best !== 16'h0001) begin
      errors++;
      $display("FAIL round2_best: got %h want 0001", best);
    end
    run_round("round3", 40);
    checks++;
    if (best !== 16'h0001 || cur !== 16'h0010) begin
      errors++;
      $display("FAIL round3: best %h cur %h want best 0001 cur 0010", best, cur);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_round("random", $urandom_range(0, 120));
  endtask

  task automatic test_foul();
    int bad;
    bus.start = 1'b1;
    @(posedge ck); #1;
    bus.start = 1'b0;
    wait_edges($urandom_range(0, 5));
    bus.btn = 1'b1;
    @(posedge ck); #1;
    bus.btn = 1'b0;
    checks++;
    if (cur !== 16'hFFFF || bus.busy !== 1'b0 || bus.led_go !== 1'b0 || best !== to_bcd(m_best)) begin
      errors++;
      $display("FAIL foul: cur %h busy %b led_go %b best %h want FFFF 0 0 %h",
               cur, bus.busy, bus.led_go, best, to_bcd(m_best));
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      bus.btn = ($urandom_range(0, 1) == 1);
      @(posedge ck); #1;
      if (bus.led_go !== 1'b0 || bus.busy !== 1'b0 || cur !== 16'hFFFF || best !== to_bcd(m_best)) bad++;
    end
    bus.btn = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL foul_hold: %0d disturbed cycles, want 0", bad);
    end
    bus.start = 1'b1;
    @(posedge ck); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.led_go !== 1'b0 || cur !== 16'h0000) begin
      errors++;
      $display("FAIL foul_restart: busy %b led_go %b cur %h want 1 0 0000", bus.busy, bus.led_go, cur);
    end
    bus.btn = 1'b1;
    @(posedge ck); #1;
    bus.btn = 1'b0;
    checks++;
    if (cur !== 16'hFFFF || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL foul_again: cur %h busy %b want FFFF 0", cur, bus.busy);
    end
  endtask

  task automatic test_saturation();
    run_round("saturate", 10000 * TICK_DIV + 8);
    checks++;
    if (cur !== 16'h9999) begin
      errors++;
      $display("FAIL sat_hold: got %h want 9999", cur);
    end
  endtask

  task automatic test_back_to_back();
    // Press lands on a tick edge: that tick must not be counted.
    for (int i = 0; i < 3; i++) run_round("coincident", TICK_DIV * $urandom_range(1, 30) + TICK_DIV - 1);
  endtask

  task automatic test_async_reset();
    int exp_wait, cnt;
    pick_start(exp_wait);
    cnt = 0;
    while (bus.led_go !== 1'b1 && cnt < exp_wait * TICK_DIV + 16) begin
      @(posedge ck); #1;
      cnt++;
    end
    checks++;
    if (bus.led_go !== 1'b1) begin
      errors++;
      $display("FAIL arst_go: led_go %b after %0d cycles want 1", bus.led_go, cnt);
    end
    wait_edges($urandom_range(3, 30));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.led_go !== 1'b0 || bus.busy !== 1'b0 || cur !== 16'h0000 || best !== 16'h9999) begin
      errors++;
      $display("FAIL arst_now: led_go %b busy %b cur %h best %h want 0 0 0000 9999",
               bus.led_go, bus.busy, cur, best);
    end
    @(posedge ck);
    @(negedge ck);
    rst_n  = 1'b1;
    m_best = 9999;
    @(posedge ck); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.led_go !== 1'b0 || best !== 16'h9999 || cur !== 16'h0000) begin
      errors++;
      $display("FAIL arst_idle: busy %b led_go %b best %h cur %h want 0 0 9999 0000",
               bus.busy, bus.led_go, best, cur);
    end
    run_round("post_reset", $urandom_range(4, 60));
  endtask

  initial begin
    test_reset();
    test_rounds();
    test_random();
    test_foul();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_reflex_ctrl
`default_nettype wire
